// File: rtl/encoder_emulator.sv
// Quadrature encoder / contact model: one accepted step gives one A/B transition, optional LFSR bounce burst, then a settle hold.
// Latency: moving line changes 1 cycle after acceptance; step_ready drops for BOUNCE_CYCLES+STEP_CYCLES cycles per step.
module encoder_emulator #(
    parameter int         STEP_CYCLES   = 64,
    parameter int         BOUNCE_CYCLES = 8,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       step_valid,
    input  logic       step_dir,
    input  logic       bounce_en,
    output logic       step_ready,
    output logic       enc_a,
    output logic       enc_b,
    output logic       busy,
    output logic [7:0] position
);

    localparam int MAX_CYC = (STEP_CYCLES > BOUNCE_CYCLES) ? STEP_CYCLES : BOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] STEP_LOAD   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic             HAS_BOUNCE  = (BOUNCE_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       r_lfsr;
    logic [7:0]       w_lfsr_nxt;
    logic [7:0]       r_pos;
    logic [7:0]       w_pos_nxt;
    logic             r_a;
    logic             r_b;
    logic             w_a_nxt;
    logic             w_b_nxt;
    logic             r_move_a;
    logic             w_move_a_nxt;
    logic             r_final;
    logic             w_final_nxt;
    logic             r_ready;
    logic             w_ready_nxt;
    logic             w_drive_en;
    logic             w_drive_val;
    logic             w_accept;
    logic             w_go_bounce;
    logic             w_cnt_zero;
    logic             w_sel_a;

    assign w_accept    = step_valid & r_ready;
    assign w_go_bounce = bounce_en & HAS_BOUNCE;
    assign w_cnt_zero  = (r_cnt == '0);
    // Gray stepping: CW moves A when A==B, CCW moves A when A!=B.
    assign w_sel_a     = ((r_a == r_b) == step_dir);
    assign w_lfsr_nxt  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_go_bounce ? BOUNCE : SETTLE;
                end
            end
            BOUNCE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_pos_nxt    = r_pos;
        w_move_a_nxt = r_move_a;
        w_final_nxt  = r_final;
        w_drive_en   = 1'b0;
        w_drive_val  = r_final;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_pos_nxt    = step_dir ? r_pos + 8'd1 : r_pos - 8'd1;
                    w_move_a_nxt = w_sel_a;
                    w_final_nxt  = w_sel_a ? ~r_a : ~r_b;
                    w_drive_en   = 1'b1;
                    if (w_go_bounce) begin
                        w_cnt_nxt   = BOUNCE_LOAD;
                        w_drive_val = w_lfsr_nxt[0];
                    end else begin
                        w_cnt_nxt   = STEP_LOAD;
                        w_drive_val = w_final_nxt;
                    end
                end
            end
            BOUNCE: begin
                w_drive_en = 1'b1;
                if (w_cnt_zero) begin
                    w_cnt_nxt   = STEP_LOAD;
                    w_drive_val = r_final;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                    w_drive_val = w_lfsr_nxt[0];
                end
            end
            SETTLE: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_cnt_nxt = '0;
        endcase
        w_a_nxt     = (w_drive_en && w_move_a_nxt)  ? w_drive_val : r_a;
        w_b_nxt     = (w_drive_en && !w_move_a_nxt) ? w_drive_val : r_b;
        w_ready_nxt = (w_state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_lfsr   <= LFSR_SEED;
            r_pos    <= 8'd0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_move_a <= 1'b0;
            r_final  <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_pos    <= w_pos_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_move_a <= w_move_a_nxt;
            r_final  <= w_final_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign step_ready = r_ready;
    assign busy       = ~r_ready;
    assign enc_a      = r_a;
    assign enc_b      = r_b;
    assign position   = r_pos;

endmodule

// File: tb/tb_encoder_emulator.sv
// Bench for encoder_emulator: phase-table/position model, LFSR-from-seed model and a simple 8-cycle debouncer.
module tb_encoder_emulator;

    localparam int         B    = 8;
    localparam int         S    = 64;
    localparam int         S0   = 3;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       step_valid;
    logic       step_dir;
    logic       bounce_en;
    logic       step_ready, enc_a, enc_b, busy;
    logic [7:0] position;
    logic       ready0, a0, b0, busy0;
    logic [7:0] pos0;

    int checks = 0;
    int errors = 0;

    encoder_emulator #(.STEP_CYCLES(S), .BOUNCE_CYCLES(B), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset_n(reset_n), .step_valid(step_valid), .step_dir(step_dir),
        .bounce_en(bounce_en), .step_ready(step_ready), .enc_a(enc_a), .enc_b(enc_b),
        .busy(busy), .position(position)
    );

    encoder_emulator #(.STEP_CYCLES(S0), .BOUNCE_CYCLES(0), .LFSR_SEED(SEED)) dut0 (
        .clk(clk), .reset_n(reset_n), .step_valid(step_valid), .step_dir(step_dir),
        .bounce_en(bounce_en), .step_ready(ready0), .enc_a(a0), .enc_b(b0),
        .busy(busy0), .position(pos0)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since reset release: the LFSR has advanced exactly this many times.
    int m_cycles;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_cycles <= 0;
        else          m_cycles <= m_cycles + 1;
    end

    logic [1:0] PH [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int         m_p;
    logic [7:0] m_pos;
    logic       deb_out;
    int         deb_cnt;
    int         deb_flips;

    function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input int n);
        logic [7:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic deb_feed(input logic v);
        if (v !== deb_out) begin
            deb_cnt++;
            if (deb_cnt == B) begin
                deb_out = v;
                deb_cnt = 0;
                deb_flips++;
            end
        end else begin
            deb_cnt = 0;
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        step_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_p     = 0;
        m_pos   = 8'd0;
    endtask

    // Called at a negedge with the main DUT idle; returns at the negedge of the next idle cycle.
    task automatic run_step(input bit dir, input bit ben, input bit hold, input bit poke);
        logic [1:0] old_ab, new_ab;
        logic [7:0] lf;
        bit         mv_a;
        int         nb;
        chk("ready_idle", step_ready, 1);
        old_ab     = PH[m_p];
        step_valid = 1'b1;
        step_dir   = dir;
        bounce_en  = ben;
        m_p        = dir ? (m_p + 1) % 4 : (m_p + 3) % 4;
        new_ab     = PH[m_p];
        m_pos      = dir ? m_pos + 8'd1 : m_pos - 8'd1;
        mv_a       = (old_ab[1] != new_ab[1]);
        nb         = ben ? B : 0;
        deb_out    = mv_a ? old_ab[1] : old_ab[0];
        deb_cnt    = 0;
        deb_flips  = 0;
        @(negedge clk);
        if (!hold) step_valid = 1'b0;
        chk("pos_next_cycle", position, m_pos);
        for (int k = 0; k < nb; k++) begin
            lf = lfsr_adv(SEED, m_cycles);
            chk("bounce_still", mv_a ? enc_b : enc_a, mv_a ? old_ab[0] : old_ab[1]);
            chk("bounce_lfsr", mv_a ? enc_a : enc_b, lf[0]);
            chk("bounce_busy", busy, 1);
            deb_feed(mv_a ? enc_a : enc_b);
            if (!hold) step_valid = (poke && k == 3);
            @(negedge clk);
        end
        for (int k = 0; k < S; k++) begin
            chk("settle_ab", {enc_a, enc_b}, new_ab);
            chk("settle_ready", step_ready, 0);
            deb_feed(mv_a ? enc_a : enc_b);
            if (!hold) step_valid = (poke && k == 10);
            @(negedge clk);
        end
        chk("idle_ready", step_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_pos", position, m_pos);
        chk("idle_ab", {enc_a, enc_b}, new_ab);
        if (ben) chk("debounce_edges", deb_flips, 1);
    endtask

    initial begin
        logic [1:0] nab;
        bit         d, h;
        reset_n    = 1'b0;
        step_valid = 1'b0;
        step_dir   = 1'b0;
        bounce_en  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ab", {enc_a, enc_b}, 2'b00);
        chk("rst_pos", position, 0);
        chk("rst_ready", step_ready, 1);
        chk("rst_busy", busy, 0);
        do_reset();
        chk("post_rst_ready", step_ready, 1);

        // Four CW steps, valid held, no bounce: 10,11,01,00 and position 4.
        for (int i = 0; i < 4; i++) run_step(1'b1, 1'b0, 1'b1, 1'b0);
        step_valid = 1'b0;
        chk("cw4_pos", position, 8'd4);

        // Single CCW step from reset wraps position to FF.
        do_reset();
        run_step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ccw_pos", position, 8'hFF);
        chk("ccw_ab", {enc_a, enc_b}, 2'b01);

        // Bounce CW step with pokes during BOUNCE and SETTLE.
        do_reset();
        run_step(1'b1, 1'b1, 1'b0, 1'b0);
        run_step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("poke_pos", position, 8'd0);

        // Reset during BOUNCE of a CW step from 11.
        do_reset();
        run_step(1'b1, 1'b0, 1'b0, 1'b0);
        run_step(1'b1, 1'b0, 1'b0, 1'b0);
        step_valid = 1'b1;
        step_dir   = 1'b1;
        bounce_en  = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_bounce_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_ab", {enc_a, enc_b}, 2'b00);
        chk("arst_busy", busy, 0);
        chk("arst_ready", step_ready, 1);
        chk("arst_pos", position, 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_p     = 0;
        m_pos   = 8'd0;
        run_step(1'b1, 1'b1, 1'b0, 1'b0);

        // Randomized mix of direction, bounce, back-to-back and pokes.
        for (int i = 0; i < 10; i++) begin
            d = 1'($urandom_range(0, 1));
            h = 1'($urandom_range(0, 1));
            run_step(d, 1'($urandom_range(0, 1)), h, !h && ($urandom_range(0, 1) == 1));
        end
        step_valid = 1'b0;

        // BOUNCE_CYCLES=0 instance: bounce_en has no effect, period 1+S0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            d = 1'($urandom_range(0, 1));
            chk("b0_ready", ready0, 1);
            step_valid = 1'b1;
            step_dir   = d;
            bounce_en  = 1'b1;
            m_p        = d ? (m_p + 1) % 4 : (m_p + 3) % 4;
            m_pos      = d ? m_pos + 8'd1 : m_pos - 8'd1;
            nab        = PH[m_p];
            @(negedge clk);
            for (int k = 0; k < S0; k++) begin
                chk("b0_ab", {a0, b0}, nab);
                chk("b0_busy", busy0, 1);
                @(negedge clk);
            end
            chk("b0_pos", pos0, m_pos);
        end
        step_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
